clk_div_bank: RTL
=================

# clk_div_bank

Multi-channel programmable clock-enable/divider bank generalising the fixed 1 Hz divider. It produces N_CH independent divided square waves with runtime-programmable period and high time, plus a one-cycle tick per period. Configuration updates are shadowed and applied glitch-free at period boundaries. It sits between the board clock and slow consumers such as display scanning, LED blinking and debouncers, and all outputs are synchronous to clk.

## Interface
- N_CH, 4, number of output channels (1..16)
- CNT_W, 28, counter/divide width
- DEF_DIV, 50_000_000, reset period in clk cycles, all channels
- DEF_HIGH, 25_000_000, reset high time in clk cycles, all channels
- CH_W, derived, $clog2(N_CH) with a minimum of 1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  N_CH  per-channel run enable
- sync  in  1  one-cycle pulse; restarts all channel phases together
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_ch  in  CH_W  target channel
- cfg_div  in  CNT_W  new period (cycles)
- cfg_high  in  CNT_W  new high time (cycles)
- clk_out  out  N_CH  divided square waves, registered
- tick  out  N_CH  one-cycle pulse at each period start, registered

## Operation
- Each channel holds: active div/high, shadow div/high, pending flag, and cnt[CNT_W-1:0].
- Reset values: cnt=0, active=DEF_DIV/DEF_HIGH, pending=0, clk_out=0, tick=0.
- Enabled channel, div≥1:
  - cnt_next = (cnt==div-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < high).
  - tick <= (cnt_next==0).
- Result: period = div cycles, high time = min(high, div). A rising clk_out coincides with tick.
- high=0 gives clk_out constant 0. high≥div gives constant 1, with ticks still emitted.
- div=1: tick every cycle.
- div=0: channel idle. cnt held 0, clk_out=0, tick=0. A pending update applies on the next edge.
- en[i]=0: cnt and clk_out hold, tick=0. The shadow is not applied until the channel runs to a boundary.
- Config handshake:
  - cfg_ready = !pending[cfg_ch].
  - On accept, the shadow is loaded and pending=1.
  - The shadow is copied to active on the edge where cnt_next==0, which is also the edge where tick rises. That edge's cnt_next uses the old div; its clk_out uses the new high. pending then clears.
  - cfg_ch ≥ N_CH: cfg_ready=1 and the write is dropped.
- sync:
  - All channels: cnt<=0, tick<=1 if div≠0, clk_out <= (0<high).
  - All pending shadows, including one accepted in the same cycle, are applied.
  - sync overrides en.
- rst has priority over sync and cfg. rst mid-period aborts the period and discards pending writes.

## Timing
- Config to effect: at most one full old period after accept; exactly 1 edge when sync, div=0, or the accept lands on the boundary cycle.
- Outputs have 1-cycle register latency from cnt_next. There is no combinational path from any input to outputs.
- cfg_ready is combinational from cfg_ch and the pending flags.
- Back-to-back writes to different channels are accepted every cycle. A second write to the same channel stalls until that channel's boundary.

## Structure
- Package clk_div_pkg holds CNT_W, DEF_DIV, DEF_HIGH and a chan_cfg_t struct {div, high}.
- Sub-module clk_div_chan, one instance per channel, contains the counter, shadow/active registers, pending flag, and the output registers.
- Top level contains the cfg decode, ready mux, sync fan-out, and the generate loop.

## Test plan
- Reset, N_CH=2, override DEF_DIV=4, DEF_HIGH=2, en=11 -> clk_out[0] = 1,1,0,0 repeating, starting on the first post-reset edge after cnt=1 (1,0,0,1,1,0,0…); tick on cnt_next=0 every 4 cycles.
- Write ch1 div=6 high=3 mid-period -> pending; old period (4) completes; ticks then spaced 6 with 3-high duty; cfg_ready low for ch1 until that boundary.
- Second write to ch1 while pending -> cfg_ready=0, stalls; write to ch0 in same window accepted immediately.
- Edge values: high=0 gives constant 0 with ticks; high=9 with div=6 gives constant 1; div=1 gives tick every cycle; div=0 gives idle, and a later write applies next edge.
- sync pulse with channels at cnt 2 and 5 -> both tick next edge and stay phase-aligned; a cfg accepted the same cycle is applied.
- en[0]=0 for 3 cycles -> cnt and clk_out frozen, no tick, period extended by exactly 3; rst asserted mid-period with a pending write -> outputs 0, DEF values restored, write lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider bank.
package clk_div_pkg;

    localparam int CNT_W = 28;

    localparam logic [CNT_W-1:0] DEF_DIV  = 28'd50_000_000;
    localparam logic [CNT_W-1:0] DEF_HIGH = 28'd25_000_000;

    // One channel's programmable shape: period and high time, both in clk cycles.
    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } chan_cfg_t;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write channel of the divider bank (valid/ready handshake).
interface clk_div_bank_if #(
    parameter int N_CH = 4
);
    import clk_div_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow configuration, pending flag
// and the registered clk_out/tick outputs.
module clk_div_chan #(
    parameter logic [clk_div_pkg::CNT_W-1:0] DEF_DIV  = clk_div_pkg::DEF_DIV,
    parameter logic [clk_div_pkg::CNT_W-1:0] DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  wr,
    input  clk_div_pkg::chan_cfg_t wr_cfg,
    output logic                  clk_out,
    output logic                  tick,
    output logic                  pending
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    chan_cfg_t        active, active_next;
    chan_cfg_t        shadow, shadow_eff;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pending_eff, pending_next;
    logic             clk_out_next, tick_next;

    // A write accepted this cycle counts as pending already, so it can land on
    // this very edge when the edge is a boundary, a sync, or the channel is idle.
    assign pending_eff = pending | wr;
    assign shadow_eff  = wr ? wr_cfg : shadow;

    // Next-state: sync restart, idle hold, frozen hold, or normal count.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        active_next  = active;
        pending_next = pending_eff;
        cnt_next     = cnt;
        clk_out_next = clk_out;
        tick_next    = 1'b0;

        if (sync) begin
            if (pending_eff) begin
                active_next  = shadow_eff;
                pending_next = 1'b0;
            end
            cnt_next     = '0;
            tick_next    = (active_next.div != '0);
            clk_out_next = (active_next.div != '0) && (active_next.high != '0);
        end else if (active.div == '0) begin
            if (pending_eff) begin
                active_next  = shadow_eff;
                pending_next = 1'b0;
            end
            cnt_next     = '0;
            clk_out_next = 1'b0;
        end else if (en) begin
            cnt_next = (cnt == active.div - ONE) ? '0 : cnt + ONE;
            // The boundary edge counts with the old div but shapes with the new high.
            if ((cnt_next == '0) && pending_eff) begin
                active_next  = shadow_eff;
                pending_next = 1'b0;
            end
            clk_out_next = (cnt_next < active_next.high);
            tick_next    = (cnt_next == '0);
        end
    end

    // State and output registers; reset restores defaults and drops pending writes.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            active  <= '{div: DEF_DIV, high: DEF_HIGH};
            cnt     <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            active  <= active_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            clk_out <= clk_out_next;
            tick    <= tick_next;
        end
    end

    // Shadow capture on an accepted write.
    always_ff @(posedge clk) begin
        // NOTE: shadow has no reset; it is only consumed while pending is set,
        // and reset clears pending.
        if (wr) begin
            shadow <= wr_cfg;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers sharing one configuration port
// and one phase-restart pulse.
module clk_div_bank #(
    parameter int                            N_CH     = 4,
    parameter logic [clk_div_pkg::CNT_W-1:0] DEF_DIV  = clk_div_pkg::DEF_DIV,
    parameter logic [clk_div_pkg::CNT_W-1:0] DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    clk_div_bank_if.slave     cfg,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   tick
);
    import clk_div_pkg::*;

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;
    logic            ch_ok;
    chan_cfg_t       wr_cfg;

    assign ch_ok  = (int'(cfg.cfg_ch) < N_CH);
    assign wr_cfg = '{div: cfg.cfg_div, high: cfg.cfg_high};

    // Ready mux: a channel takes a new write only once its previous one has landed;
    // out-of-range channels always look ready so the write is silently dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        if (ch_ok) begin
            cfg.cfg_ready = ~pending[cfg.cfg_ch];
        end
    end

    // Write decode: one-hot strobe to the addressed channel on an accepted write.
    always_comb begin
        wr = '0;
        if (cfg.cfg_valid && cfg.cfg_ready && ch_ok) begin
            wr[cfg.cfg_ch] = 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_div_chan #(
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_cfg  (wr_cfg),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule
